// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type and frame constants for the PS/2 byte receiver
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, RESYNC} ps2_rx_state_t;
  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: N-stage synchroniser on PS/2 clock and data with registered falling-edge detect
module ps2_sync_edge #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic d
);
  logic [N-1:0] cs, ds;
  logic cq;
  always_ff @(posedge clk) begin
    if (reset) begin
      cs <= '1;
      ds <= '1;
      cq <= 1'b1;
      fall <= 1'b0;
      d <= 1'b1;
    end else begin
      cs <= {cs[N-2:0], ps2_clk};
      ds <= {ds[N-2:0], ps2_data};
      cq <= cs[N-1];
      fall <= cq & ~cs[N-1];
      d <= ds[N-1];
    end
  end
endmodule

// File: rtl/ps2_byte_receiver.sv
// ps2_byte_receiver: de-frames PS/2 11-bit frames into bytes; PS2_PARITY_CHECK_EN enables odd-parity checking
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out_byte,
  output logic       valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  ps2_rx_state_t state, nxt;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic [TW-1:0] idle;
  logic p, fall, d, tout, par, parity_ok, nvalid, nerr;
  ps2_sync_edge #(.N(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .fall(fall),
    .d(d)
  );
  assign tout = !fall && idle == TMAX && (state == DATA || state == PARITY || state == STOP);
  assign par = ^{sr, p};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      p <= 1'b0;
      idle <= '0;
      out_byte <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= nxt;
      idle <= fall ? '0 : (idle == TMAX ? idle : idle + 1'b1);
      valid <= nvalid;
      frame_err <= nerr;
      if (fall && state == IDLE && !d) begin
        cnt <= '0;
        sr <= '0;
      end
      if (fall && state == DATA) begin
        sr <= {d, sr[7:1]};
        cnt <= cnt + 1'b1;
      end
      if (fall && state == PARITY) p <= d;
      if (nvalid) out_byte <= sr;
    end
  end
  always_comb begin
    nxt = state;
    if (tout) nxt = IDLE;
    else if (fall)
      case (state)
        IDLE:    nxt = d ? IDLE : DATA;
        DATA:    nxt = cnt == 3'(PS2_DATA_BITS - 1) ? PARITY : DATA;
        PARITY:  nxt = STOP;
        STOP:    nxt = d ? IDLE : RESYNC;
        RESYNC:  nxt = d ? IDLE : RESYNC;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    parity_ok = par;
`else
    // parity bit is still latched so the datapath matches the checking build
    parity_ok = par | 1'b1;
`endif
    nvalid = fall && state == STOP && d && parity_ok;
    nerr = tout || (fall && state == STOP && !(d && parity_ok));
  end
endmodule

// File: tb/tb_ps2_byte_receiver.sv
// tb_ps2_byte_receiver: directed frame-level checks of the PS/2 byte receiver
module tb_ps2_byte_receiver;
  localparam int TO = 200;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] out_byte;
  logic valid, frame_err;
  int vectors = 0, errors = 0, vcnt = 0, ecnt = 0, v0 = 0, e0 = 0;
  bit both = 1'b0;
  logic [7:0] got[$];

  ps2_byte_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .out_byte(out_byte),
    .valid(valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (valid) begin
      vcnt++;
      got.push_back(out_byte);
    end
    if (frame_err) ecnt++;
    if (valid && frame_err) both = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(5);
    ps2_clk = 1'b0;
    cyc(10);
    ps2_clk = 1'b1;
    cyc(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    v0 = vcnt;
    e0 = ecnt;
  endtask

  initial begin
    cyc(3);
    check("rst_out_byte", 32'(out_byte), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    cyc(10);
    mark();
    send_frame(8'hA5, 1'b1, 1'b1);
    check("a5_valid_cnt", 32'(vcnt - v0), 32'd1);
    check("a5_err_cnt", 32'(ecnt - e0), 32'd0);
    check("a5_out_byte", 32'(out_byte), 32'hA5);
    check("a5_logged", 32'(got[got.size() - 1]), 32'hA5);
    mark();
    send_frame(8'hA5, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_err_cnt", 32'(ecnt - e0), 32'd1);
    check("badpar_valid_cnt", 32'(vcnt - v0), 32'd0);
`else
    check("badpar_err_cnt", 32'(ecnt - e0), 32'd0);
    check("badpar_valid_cnt", 32'(vcnt - v0), 32'd1);
`endif
    check("badpar_out_byte", 32'(out_byte), 32'hA5);
    mark();
    send_frame(8'h08, 1'b0, 1'b0);
    check("stop0_err_cnt", 32'(ecnt - e0), 32'd1);
    check("stop0_valid_cnt", 32'(vcnt - v0), 32'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    check("resync_err_cnt", 32'(ecnt - e0), 32'd1);
    check("resync_valid_cnt", 32'(vcnt - v0), 32'd1);
    check("resync_out_byte", 32'(out_byte), 32'h3C);
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(TO + 50);
    check("tout_err_cnt", 32'(ecnt - e0), 32'd1);
    check("tout_valid_cnt", 32'(vcnt - v0), 32'd0);
    cyc(TO + 50);
    check("tout_err_once", 32'(ecnt - e0), 32'd1);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("post_tout_valid", 32'(vcnt - v0), 32'd1);
    check("post_tout_byte", 32'(out_byte), 32'h5A);
    mark();
    send_frame(8'h09, 1'b1, 1'b1);
    send_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1);
    check("b2b_done", 32'(vcnt - v0), 32'd3);
    check("b2b_err_cnt", 32'(ecnt - e0), 32'd0);
    check("b2b_byte0", 32'(got[got.size() - 3]), 32'h09);
    check("b2b_byte1", 32'(got[got.size() - 2]), 32'h12);
    check("b2b_byte2", 32'(got[got.size() - 1]), 32'h34);
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(5);
    ps2_clk = 1'b0;
    cyc(5);
    reset = 1'b1;
    cyc(2);
    ps2_clk = 1'b1;
    cyc(3);
    check("midrst_out_byte", 32'(out_byte), 32'h00);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    cyc(20);
    check("midrst_err_cnt", 32'(ecnt - e0), 32'd0);
    send_frame(8'hFF, 1'b1, 1'b1);
    check("ff_valid_cnt", 32'(vcnt - v0), 32'd1);
    check("ff_out_byte", 32'(out_byte), 32'hFF);
    check("ff_err_cnt", 32'(ecnt - e0), 32'd0);
    check("valid_err_exclusive", 32'(both), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
